// File: rtl/pll_reset_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// default count constants and a constant clog2 helper for the counter width.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST  = 3'd0,
        ST_WAIT    = 3'd1,
        ST_STABLE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_READY   = 3'd4
    } state_e;

    localparam int unsigned DEF_LOCK_CYCLES    = 1024;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_STAGE_GAP      = 16;
    localparam int unsigned DEF_NUM_STAGES     = 3;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (((v - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max4_f(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the reset sequencer and its surroundings (PLL wrapper,
// stage consumers), plus a debug view of the sequencer state.
interface pll_reset_seq_if #(
    parameter int unsigned NUM_STAGES = 3
);
    import pll_reset_pkg::*;

    // No valid/ready handshake here: every signal is a level, pll_lock is
    // asynchronous to the sequencer clock and all outputs are registered levels.
    logic                  pll_lock;
    logic                  pll_reset_o;
    logic [NUM_STAGES-1:0] stage_rst_n_o;
    logic                  ready_o;
    logic                  locked_o;
    logic [7:0]            retry_count_o;
    state_e                dbg_state_o;

    modport master (
        input  pll_lock,
        output pll_reset_o, stage_rst_n_o, ready_o, locked_o, retry_count_o, dbg_state_o
    );

    modport slave (
        output pll_lock,
        input  pll_reset_o, stage_rst_n_o, ready_o, locked_o, retry_count_o, dbg_state_o
    );

endinterface

// File: rtl/pll_reset_seq_sync2_n.sv
// Two-flop synchroniser with asynchronous active-low clear; used for the PLL
// lock flag here and for each stage reset in its consumer domain.
module sync2_n (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock with a stability
// window, retries on lock timeout, then releases staged resets and flags ready.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP,
    parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES
) (
    input  logic            clock,
    input  logic            reset_n,
    pll_reset_seq_if.master bus
);

    localparam int unsigned CW = clog2_f(max4_f(LOCK_CYCLES, TIMEOUT_CYCLES,
                                                PLL_RST_CYCLES, STAGE_GAP * NUM_STAGES)) + 1;

    localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    // The lock_s=1 sample seen in ST_WAIT is stable cycle 1, so the counter
    // in ST_STABLE only needs to cover the remaining LOCK_CYCLES-1 samples.
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_CYCLES - 2);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(NUM_STAGES * STAGE_GAP - 1);

    logic lock_s;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            retry_q, retry_d;
    logic                  pll_reset_q;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ready_q;

    sync2_n u_lock_sync (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .d_i     (bus.pll_lock),
        .q_o     (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_PLLRST: begin
                if (cnt_q == PLLRST_LAST) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLLRST;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) state_d = ST_WAIT;
                else if (cnt_q == STABLE_LAST) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!lock_s) state_d = ST_WAIT;
                else if (cnt_q == RELEASE_LAST) state_d = ST_READY;
            end
            ST_READY: begin
                if (!lock_s) state_d = ST_WAIT;
            end
            default: state_d = ST_PLLRST;
        endcase

        // ST_READY holds its counter so it never wraps while parked there.
        if (state_d != state_q)      cnt_d = '0;
        else if (state_q == ST_READY) cnt_d = cnt_q;
        else                          cnt_d = cnt_q + CW'(1);

        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            stage_d[k] = (state_d == ST_READY) ||
                         ((state_d == ST_RELEASE) && (cnt_d >= CW'(k * STAGE_GAP)));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PLLRST;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            pll_reset_q <= 1'b1;
            stage_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == ST_PLLRST);
            stage_q     <= stage_d;
            ready_q     <= (state_d == ST_READY);
        end
    end

    assign bus.pll_reset_o   = pll_reset_q;
    assign bus.stage_rst_n_o = stage_q;
    assign bus.ready_o       = ready_q;
    assign bus.locked_o      = lock_s;
    assign bus.retry_count_o = retry_q;
    assign bus.dbg_state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with small counts: directed lock patterns, expected
// outputs tagged with the edge number they must appear on.
module tb_pll_reset_seq;

  localparam int W = 30;

  logic clock;
  logic reset_n;
  int   edge_n;

  pll_reset_seq_if #(.NUM_STAGES(3)) bus_if ();

  pll_reset_seq #(
    .LOCK_CYCLES    (8),
    .TIMEOUT_CYCLES (32),
    .PLL_RST_CYCLES (4),
    .STAGE_GAP      (4),
    .NUM_STAGES     (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if.master)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  // scoreboard: {edge[15:0], pll_reset, stage[2:0], ready, locked, retry[7:0]}
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic exp(input int cyc, input bit prst, input logic [2:0] st, input bit rdy,
                     input bit lk, input int rt, input string nm);
    logic [15:0] c;
    logic [7:0]  r;
    c = 16'(cyc);
    r = 8'(rt);
    exp_q.push_back({c, prst, st, rdy, lk, r});
    name_q.push_back(nm);
  endtask

  // driver tasks
  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clock);
  endtask

  task automatic do_reset(input bit lock_val, input string nm);
    @(posedge clock);
    #1;
    exp(0, 1'b1, 3'b000, 1'b0, 1'b0, 0, nm);
    reset_n = 1'b0;
    bus_if.pll_lock = lock_val;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    logic [13:0]  obs;
    string        nm;
    forever begin
      @(negedge clock);
      obs = {bus_if.pll_reset_o, bus_if.stage_rst_n_o, bus_if.ready_o,
             bus_if.locked_o, bus_if.retry_count_o};
      while (exp_q.size() > 0 && int'(exp_q[0][29:14]) <= edge_n) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (int'(e[29:14]) != edge_n) begin
          n_fail++;
          $display("FAIL %s: check for edge %0d not reached in order (now edge %0d)",
                   nm, e[29:14], edge_n);
        end else if (obs !== e[13:0]) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got prst=%b stage=%b ready=%b locked=%b retry=%0d, want prst=%b stage=%b ready=%b locked=%b retry=%0d",
                   nm, edge_n, obs[13], obs[12:10], obs[9], obs[8], obs[7:0],
                   e[13], e[12:10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus_if.pll_lock = 1'b0;

    // nominal start, then lock loss in ST_READY and replay
    do_reset(1'b0, "t1_reset");
    exp(3,  1, 3'b000, 0, 0, 0, "t1_pllrst_hold");
    exp(4,  0, 3'b000, 0, 0, 0, "t1_pllrst_end");
    exp(11, 0, 3'b000, 0, 0, 0, "t1_sync_latency");
    exp(12, 0, 3'b000, 0, 1, 0, "t1_lock_s");
    exp(19, 0, 3'b000, 0, 1, 0, "t1_pre_release");
    exp(20, 0, 3'b001, 0, 1, 0, "t1_stage0");
    exp(23, 0, 3'b001, 0, 1, 0, "t1_gap");
    exp(24, 0, 3'b011, 0, 1, 0, "t1_stage1");
    exp(28, 0, 3'b111, 0, 1, 0, "t1_stage2");
    exp(31, 0, 3'b111, 0, 1, 0, "t1_pre_ready");
    exp(32, 0, 3'b111, 1, 1, 0, "t1_ready");
    exp(35, 0, 3'b111, 1, 1, 0, "t4_hold_ready");
    exp(36, 0, 3'b111, 1, 0, 0, "t4_lock_s_low");
    exp(37, 0, 3'b000, 0, 0, 0, "t4_drop");
    exp(41, 0, 3'b000, 0, 0, 0, "t4_wait");
    exp(42, 0, 3'b000, 0, 1, 0, "t4_relock");
    exp(49, 0, 3'b000, 0, 1, 0, "t4_pre_release");
    exp(50, 0, 3'b001, 0, 1, 0, "t4_stage0");
    exp(54, 0, 3'b011, 0, 1, 0, "t4_stage1");
    exp(58, 0, 3'b111, 0, 1, 0, "t4_stage2");
    exp(61, 0, 3'b111, 0, 1, 0, "t4_pre_ready");
    exp(62, 0, 3'b111, 1, 1, 0, "t4_ready");
    wait_edge(10); bus_if.pll_lock = 1'b1;
    wait_edge(34); bus_if.pll_lock = 1'b0;
    wait_edge(40); bus_if.pll_lock = 1'b1;
    wait_edge(64);

    // asynchronous reset in the middle of ST_RELEASE
    do_reset(1'b0, "t5_initial_reset");
    exp(20, 0, 3'b001, 0, 1, 0, "t5_stage0");
    exp(24, 0, 3'b011, 0, 1, 0, "t5_stage1");
    wait_edge(10); bus_if.pll_lock = 1'b1;
    wait_edge(25);
    do_reset(1'b1, "t5_async_reset");
    exp(1,  1, 3'b000, 0, 0, 0, "t5_restart_sync");
    exp(3,  1, 3'b000, 0, 1, 0, "t5_restart_pllrst");
    exp(4,  0, 3'b000, 0, 1, 0, "t5_restart_wait");
    exp(11, 0, 3'b000, 0, 1, 0, "t5_restart_stable");
    exp(12, 0, 3'b001, 0, 1, 0, "t5_restart_stage0");
    wait_edge(14);

    // one-cycle lock glitch during ST_STABLE
    do_reset(1'b0, "t3_reset");
    exp(13, 0, 3'b000, 0, 1, 0, "t3_stable");
    exp(16, 0, 3'b000, 0, 0, 0, "t3_glitch");
    exp(17, 0, 3'b000, 0, 1, 0, "t3_lock_back");
    exp(20, 0, 3'b000, 0, 1, 0, "t3_no_early_release");
    exp(24, 0, 3'b000, 0, 1, 0, "t3_still_counting");
    exp(25, 0, 3'b001, 0, 1, 0, "t3_stage0");
    exp(29, 0, 3'b011, 0, 1, 0, "t3_stage1");
    wait_edge(10); bus_if.pll_lock = 1'b1;
    wait_edge(14); bus_if.pll_lock = 1'b0;
    wait_edge(15); bus_if.pll_lock = 1'b1;
    wait_edge(30);

    // lock arrives in the same cycle as the timeout terminal count
    do_reset(1'b0, "t6_reset");
    exp(35, 0, 3'b000, 0, 1, 0, "t6_lock_at_31");
    exp(36, 0, 3'b000, 0, 1, 0, "t6_no_pulse");
    exp(37, 0, 3'b000, 0, 1, 0, "t6_no_retry");
    exp(42, 0, 3'b000, 0, 1, 0, "t6_pre_release");
    exp(43, 0, 3'b001, 0, 1, 0, "t6_stage0");
    wait_edge(33); bus_if.pll_lock = 1'b1;
    wait_edge(45);

    // lock never arrives: periodic retries saturating at 255
    do_reset(1'b0, "t2_reset");
    exp(35,   0, 3'b000, 0, 0, 0,   "t2_before_timeout");
    exp(36,   1, 3'b000, 0, 0, 1,   "t2_first_retry");
    exp(39,   1, 3'b000, 0, 0, 1,   "t2_pulse_end");
    exp(40,   0, 3'b000, 0, 0, 1,   "t2_back_to_wait");
    exp(71,   0, 3'b000, 0, 0, 1,   "t2_wait_full");
    exp(72,   1, 3'b000, 0, 0, 2,   "t2_second_retry");
    exp(9179, 0, 3'b000, 0, 0, 254, "t2_retry_254");
    exp(9180, 1, 3'b000, 0, 0, 255, "t2_retry_255");
    exp(9215, 0, 3'b000, 0, 0, 255, "t2_wait_sat");
    exp(9216, 1, 3'b000, 0, 0, 255, "t2_saturate");
    exp(9220, 0, 3'b000, 0, 0, 255, "t2_sat_wait");
    wait_edge(9222);

    repeat (3) @(negedge clock);
    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected check for edge %0d never evaluated", name_q[0], exp_q[0][29:14]);
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
Reset sequencer directly downstream of the PLL wrapper. It consumes the PLL lock flag, qualifies it with a stability window and retries the PLL on lock timeout. It then releases a set of staged, active-low reset requests (PHY first, then controller, then AXI fabric) and flags system ready. It runs on the free-running board input clock, the same clock that feeds the PLL, so it keeps running while the PLL is unlocked. Each stage reset is re-synchronised into its consumer domain by the consumer.

Parameters:
LOCK_CYCLES, 1024, consecutive lock_s=1 cycles required before the first stage release
TIMEOUT_CYCLES, 65536, cycles spent waiting for lock before the PLL is reset again
PLL_RST_CYCLES, 16, pll_reset_o pulse width in cycles
STAGE_GAP, 16, cycles between successive stage releases, and between the last release and ready_o
NUM_STAGES, 3, number of staged reset outputs (bit 0 is released first)
CW, derived, clog2 of the largest count parameter, plus 1

Ports:
clock  in  1  free-running reference clock (PLL input clock)
reset_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL lock flag, asynchronous to clock
pll_reset_o  out  1  active-high PLL reset request
stage_rst_n_o  out  NUM_STAGES  active-low staged reset requests
ready_o  out  1  all stages released, lock still held
locked_o  out  1  synchronised lock (lock_s)
retry_count_o  out  8  PLL retry count caused by timeout, saturates at 255

Behaviour:
- Reset (async assert, sync release): state ST_PLLRST, counter 0, pll_reset_o=1, stage_rst_n_o=0, ready_o=0, locked_o=0, retry_count_o=0, both sync flops 0.
- lock_s: 2-flop synchroniser on pll_lock; 2-cycle latency. All decisions use lock_s.
- All outputs are registered. Each output is a function of the next state.
- A single counter cnt clears on every state change.
- ST_PLLRST: pll_reset_o=1. After PLL_RST_CYCLES cycles in the state, go to ST_WAIT.
- ST_WAIT:
  - lock_s=1: go to ST_STABLE.
  - Otherwise, when cnt==TIMEOUT_CYCLES-1: go to ST_PLLRST and increment retry_count_o (saturating).
- ST_STABLE:
  - lock_s=0: go to ST_WAIT. The timeout restarts and retry_count_o is unchanged.
  - The entry cycle counts as stable cycle 1. On stable cycle LOCK_CYCLES, go to ST_RELEASE.
- ST_RELEASE:
  - stage k is released (stage_rst_n_o[k]=1) at entry + k*STAGE_GAP.
  - Stage 0 is released on the entry edge itself.
  - At entry + NUM_STAGES*STAGE_GAP, go to ST_READY with ready_o=1.
  - Released stages stay released.
- ST_READY: hold. ready_o=1 and all stages released.
- Lock loss: lock_s=0 in ST_RELEASE or ST_READY causes, on the next edge:
  - all stage_rst_n_o=0 and ready_o=0 simultaneously;
  - transition to ST_WAIT.
  - The PLL is not reset and retry_count_o is unchanged.
- Precedence:
  - lock loss beats any counter terminal event in the same cycle;
  - in ST_WAIT, lock_s=1 beats timeout in the same cycle.
- Illegal state encodings go to ST_PLLRST.
- A mid-sequence reset_n assertion forces the reset values immediately, without waiting for a clock edge.

Decomposition:
- Package pll_reset_pkg holds:
  - the state enum (ST_PLLRST, ST_WAIT, ST_STABLE, ST_RELEASE, ST_READY);
  - the default count constants;
  - a clog2 function for CW.
- Sub-module sync2_n: a 2-flop synchroniser with asynchronous active-low clear. It is reused for lock_s and, in consumer domains, for each stage reset.

Test Plan:
Bench parameters for every scenario: LOCK_CYCLES=8, TIMEOUT_CYCLES=32, PLL_RST_CYCLES=4, STAGE_GAP=4, NUM_STAGES=3. Edge numbers count from the first edge after reset_n rises.
1. Nominal start; pll_lock rises at edge 10 and stays high -> pll_reset_o low from edge 4; lock_s=1 at edge 12; stage 0 released at edge 20, stage 1 at 24, stage 2 at 28; ready_o=1 at 32; retry_count_o=0.
2. pll_lock held low -> pll_reset_o re-pulses for 4 cycles after every 32 cycles in ST_WAIT; retry_count_o increments once per pulse and sticks at 255 after 255 timeouts.
3. Lock glitches low for 1 cycle during ST_STABLE -> no stage released; the stability count restarts, and stage 0 is released 8 stable cycles after lock_s returns to 1.
4. Lock drops in ST_READY -> the edge after lock_s=0 shows stage_rst_n_o=000 and ready_o=0; pll_reset_o stays 0; the full sequence replays when lock returns.
5. reset_n asserted mid-ST_RELEASE (stage_rst_n_o=011) -> all outputs take their reset values immediately, with no clock edge; the sequence restarts from ST_PLLRST.
6. Lock asserts on the same edge ST_WAIT reaches cnt==31 -> the block enters ST_STABLE with no PLL reset pulse and no retry increment.
